bus_initiator: RTL and testbench

- 68030-style asynchronous bus master.
- Turns a simple single-cycle request port into AS_n/DS_n/RW/SIZ/FC bus cycles.
- Samples DSACK0_n/DSACK1_n/BERR_n from the system controller and performs dynamic bus sizing, so byte, word and long operands complete against 8-, 16- or 32-bit ports.
- Intended as a DMA/test master sharing the system bus with the CPU; arbitration is outside this block.

---
 rtl/bus_initiator_pkg.sv | 32 +++
 rtl/sync_n.sv | 20 ++
 rtl/bus_initiator.sv | 180 ++++++++++++++++++
 tb/tb_bus_initiator.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_initiator_pkg.sv
// rtl/bus_initiator_pkg.sv - shared types, SIZ encodings and DSACK decoding for bus_initiator
package bus_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ASSERT,
    ST_TERM,
    ST_DONE
  } state_t;

  localparam logic [1:0] SIZ_BYTE  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_3BYTE = 2'b11;
  localparam logic [1:0] SIZ_LONG  = 2'b00;

  // Responding port width in bytes; 0 means no termination yet.
  function automatic logic [2:0] port_bytes(input logic dsack1_n, input logic dsack0_n);
    case ({dsack1_n, dsack0_n})
      2'b00:   return 3'd4;
      2'b01:   return 3'd2;
      2'b10:   return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  // Places the low nbytes of a right-justified operand on the top of the bus.
  function automatic logic [31:0] left_just(input logic [31:0] v, input logic [2:0] nbytes);
    return v << (6'd32 - {nbytes, 3'b000});
  endfunction

endpackage

// File: rtl/sync_n.sv
// rtl/sync_n.sv - STAGES-deep synchroniser for an active-low async input, resets to 1
module sync_n #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '1;
    else        chain <= (chain << 1) | STAGES'(d);
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - 68030-style async bus master with dynamic bus sizing.
// Optional ASSERT-phase timeout enabled by defining BUS_TIMEOUT_EN.
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        REQ,
  input  logic [31:0] REQ_ADDR,
  input  logic        REQ_RW,
  input  logic [1:0]  REQ_SIZE,
  input  logic [2:0]  REQ_FC,
  input  logic [31:0] REQ_WDATA,
  output logic        BUSY,
  output logic        ACK,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [31:0] A,
  output logic [2:0]  FC,
  output logic [1:0]  SIZ,
  output logic        RW,
  output logic        AS_n,
  output logic        DS_n,
  output logic [31:0] D_OUT,
  output logic        D_OE,
  input  logic [31:0] D_IN,
  input  logic        DSACK0_n,
  input  logic        DSACK1_n,
  input  logic        BERR_n
);

  localparam int DW = $clog2(SYNC_STAGES + 1);

  state_t        state_q, state_d;
  logic [31:0]   addr_q, wdata_q;
  logic [2:0]    rem_q;
  logic          rw_q;
  logic [DW-1:0] dwell_q;

  logic dsack0_s, dsack1_s, berr_s;

  sync_n #(.STAGES(SYNC_STAGES)) u_sync_dsack0 (.clk(CLK), .rst_n(RST_n), .d(DSACK0_n), .q(dsack0_s));
  sync_n #(.STAGES(SYNC_STAGES)) u_sync_dsack1 (.clk(CLK), .rst_n(RST_n), .d(DSACK1_n), .q(dsack1_s));
  sync_n #(.STAGES(SYNC_STAGES)) u_sync_berr   (.clk(CLK), .rst_n(RST_n), .d(BERR_n),   .q(berr_s));

  logic [2:0] req_bytes, pbytes, xfer_n;
  logic       misaligned, term_ok, timeout, bus_err, terminate;

  always_comb begin
    case (REQ_SIZE)
      SIZ_BYTE:  req_bytes = 3'd1;
      SIZ_WORD:  req_bytes = 3'd2;
      SIZ_3BYTE: req_bytes = 3'd3;
      SIZ_LONG:  req_bytes = 3'd4;
    endcase
  end

  assign misaligned = (REQ_SIZE == SIZ_WORD && REQ_ADDR[0]) ||
                      (REQ_SIZE == SIZ_LONG && REQ_ADDR[1:0] != 2'b00);
  assign pbytes     = port_bytes(dsack1_s, dsack0_s);
  assign xfer_n     = (pbytes < rem_q) ? pbytes : rem_q;
  // Synchroniser latency: earlier samples may still reflect the previous sub-cycle.
  assign term_ok    = dwell_q >= DW'(SYNC_STAGES);
  assign bus_err    = (term_ok && !berr_s) || timeout;
  assign terminate  = bus_err || (term_ok && pbytes != 3'd0);

`ifdef BUS_TIMEOUT_EN
  logic [7:0] tmo_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)                                       tmo_q <= '0;
    else if (state_q == ST_ADDR)                      tmo_q <= '0;
    else if (state_q == ST_ASSERT && tmo_q != 8'hFF)  tmo_q <= tmo_q + 8'd1;
  end

  assign timeout = (state_q == ST_ASSERT) && (tmo_q == 8'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^8'(TIMEOUT_CYCLES);
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (REQ) state_d = misaligned ? ST_DONE : ST_ADDR;
      ST_ADDR:   state_d = ST_ASSERT;
      ST_ASSERT: if (terminate) state_d = ST_TERM;
      ST_TERM:   state_d = (rem_q != 3'd0 && !RSP_ERR) ? ST_ADDR : ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      AS_n      <= 1'b1;
      DS_n      <= 1'b1;
      RW        <= 1'b1;
      D_OE      <= 1'b0;
      BUSY      <= 1'b0;
      ACK       <= 1'b0;
      RSP_ERR   <= 1'b0;
      RSP_RDATA <= '0;
      A         <= '0;
      FC        <= '0;
      SIZ       <= '0;
      D_OUT     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rem_q     <= '0;
      rw_q      <= 1'b1;
      dwell_q   <= '0;
    end else begin
      BUSY <= (state_d != ST_IDLE);
      ACK  <= (state_d == ST_DONE);
      case (state_q)
        ST_IDLE: if (REQ) begin
          addr_q    <= REQ_ADDR;
          wdata_q   <= REQ_WDATA;
          rem_q     <= req_bytes;
          rw_q      <= REQ_RW;
          RSP_RDATA <= '0;
          RSP_ERR   <= misaligned;
          if (!misaligned) begin
            A    <= REQ_ADDR;
            FC   <= REQ_FC;
            SIZ  <= req_bytes[1:0];
            RW   <= REQ_RW;
            D_OE <= !REQ_RW;
            if (!REQ_RW) D_OUT <= left_just(REQ_WDATA, req_bytes);
          end
        end
        ST_ADDR: begin
          AS_n    <= 1'b0;
          DS_n    <= !rw_q;
          dwell_q <= DW'(1);
        end
        ST_ASSERT: begin
          if (terminate) begin
            AS_n <= 1'b1;
            DS_n <= 1'b1;
            if (bus_err) begin
              RSP_ERR <= 1'b1;
            end else begin
              addr_q <= addr_q + {29'd0, xfer_n};
              rem_q  <= rem_q - xfer_n;
              // Bytes arrive MSB first, so shift the accumulator up and append.
              if (rw_q)
                RSP_RDATA <= (RSP_RDATA << {xfer_n, 3'b000}) |
                             (D_IN >> (6'd32 - {xfer_n, 3'b000}));
            end
          end else begin
            DS_n <= 1'b0;
            if (!term_ok) dwell_q <= dwell_q + DW'(1);
          end
        end
        ST_TERM: begin
          D_OE <= 1'b0;
          if (state_d == ST_ADDR) begin
            A    <= addr_q;
            SIZ  <= rem_q[1:0];
            D_OE <= !rw_q;
            if (!rw_q) D_OUT <= left_just(wdata_q, rem_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// tb/tb_bus_initiator.sv - randomized self-checking bench for bus_initiator
module tb_bus_initiator;

  localparam int TMO = 8;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        REQ = 1'b0;
  logic [31:0] REQ_ADDR = '0;
  logic        REQ_RW = 1'b1;
  logic [1:0]  REQ_SIZE = '0;
  logic [2:0]  REQ_FC = '0;
  logic [31:0] REQ_WDATA = '0;
  logic        BUSY, ACK, RSP_ERR, RW, AS_n, DS_n, D_OE;
  logic [31:0] RSP_RDATA, A, D_OUT, D_IN;
  logic [2:0]  FC;
  logic [1:0]  SIZ;
  logic        DSACK0_n = 1'b1, DSACK1_n = 1'b1, BERR_n = 1'b1;

  bus_initiator #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST_n(RST_n), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_RW(REQ_RW),
    .REQ_SIZE(REQ_SIZE), .REQ_FC(REQ_FC), .REQ_WDATA(REQ_WDATA), .BUSY(BUSY),
    .ACK(ACK), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .A(A), .FC(FC), .SIZ(SIZ),
    .RW(RW), .AS_n(AS_n), .DS_n(DS_n), .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN),
    .DSACK0_n(DSACK0_n), .DSACK1_n(DSACK1_n), .BERR_n(BERR_n)
  );

  always #5 CLK = ~CLK;

  // Responder memory: bytes at A, A+1, ... presented MSB-first on D[31:0].
  logic [7:0] mem [256];
  assign D_IN = {mem[A[7:0]], mem[A[7:0] + 8'd1], mem[A[7:0] + 8'd2], mem[A[7:0] + 8'd3]};

  typedef struct {
    logic [31:0] a;
    logic [1:0]  siz;
    logic [31:0] dout;
  } sub_t;

  sub_t        exp_q[$];
  sub_t        cur;
  int          checks = 0, errors = 0;
  int unsigned cyc = 0, acc_cyc = 0;
  logic        exp_rw, exp_err;
  logic [2:0]  exp_fc;
  logic [31:0] exp_rdata;
  int          exp_lat, exp_as_low;
  bit          txn_active = 0, txn_done = 0;
  int          as_low_cnt = 0, since_fall = 0, last_lat = 0;
  logic        prev_as = 1'b1, last_err = 1'b0;
  logic [31:0] last_rdata = '0;
  logic [7:0]  last_dbytes[$];

  always @(posedge CLK) cyc++;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Operand-level model: sub-cycle list, read data, error and latency.
  task automatic build_model(input logic [31:0] addr, input logic rw, input logic [1:0] size,
                             input logic [31:0] wdata, input int port, input bit berr);
    int nb, off, n, k;
    logic [7:0] ob [4];
    sub_t s;
    nb = (size == 2'b00) ? 4 : int'(size);
    for (int i = 0; i < nb; i++)
      ob[i] = rw ? mem[8'(addr + i)] : wdata[8*(nb-1-i) +: 8];
    exp_q.delete();
    exp_rdata = '0;
    exp_err = 1'b0;
    k = 0;
    if ((size == 2'b10 && addr[0]) || (size == 2'b00 && addr[1:0] != 2'b00)) begin
      exp_err = 1'b1;
      exp_lat = 1;
      exp_as_low = 0;
      return;
    end
    off = 0;
    while (off < nb) begin
      s.a = addr + off;
      s.siz = 2'(nb - off);
      s.dout = '0;
      for (int j = 0; j < 4; j++)
        if (off + j < nb) s.dout[31-8*j -: 8] = ob[off+j];
      exp_q.push_back(s);
      k++;
      if (berr || port == 0) begin
        exp_err = 1'b1;
        break;
      end
      n = (port < nb - off) ? port : nb - off;
      if (rw) for (int j = 0; j < n; j++) exp_rdata = {exp_rdata[23:0], ob[off+j]};
      off += n;
    end
    if (port == 0 && !berr) begin
      exp_lat = TMO + 3;
      exp_as_low = TMO;
    end else begin
      exp_lat = 1 + 4 * k;
      exp_as_low = 2 * k;
    end
  endtask

  always @(negedge CLK) begin
    if (RST_n && txn_active) begin
      if (!AS_n) as_low_cnt++;
      if (!AS_n && prev_as) begin
        since_fall = 0;
        if (exp_q.size() == 0) begin
          check("extra_subcycle", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("A", A, cur.a);
          check("SIZ", 32'(SIZ), 32'(cur.siz));
          check("RW", 32'(RW), 32'(exp_rw));
          check("FC", 32'(FC), 32'(exp_fc));
          check("D_OE", 32'(D_OE), 32'(!exp_rw));
          check("DS_n_first", 32'(DS_n), exp_rw ? 32'd0 : 32'd1);
          if (!exp_rw) begin
            check("D_OUT", D_OUT, cur.dout);
            last_dbytes.push_back(D_OUT[31:24]);
          end
        end
      end else if (!AS_n) begin
        since_fall++;
        if (since_fall == 1) check("DS_n_second", 32'(DS_n), 32'd0);
      end
      if (ACK) begin
        check("latency", cyc - acc_cyc + 1, exp_lat);
        check("rdata", RSP_RDATA, exp_rdata);
        check("err", 32'(RSP_ERR), 32'(exp_err));
        check("busy_at_ack", 32'(BUSY), 32'd1);
        check("as_low_cycles", as_low_cnt, exp_as_low);
        check("subcycles_left", exp_q.size(), 32'd0);
        last_rdata = RSP_RDATA;
        last_err = RSP_ERR;
        last_lat = int'(cyc - acc_cyc + 1);
        txn_active = 0;
        txn_done = 1;
      end
    end
    prev_as = AS_n;
  end

  task automatic run_txn(input logic [31:0] addr, input logic rw, input logic [1:0] size,
                         input logic [31:0] wdata, input logic [2:0] fc, input int port,
                         input bit berr, input bit wait_done);
    DSACK1_n = !(port == 4 || port == 2);
    DSACK0_n = !(port == 4 || port == 1);
    BERR_n = !berr;
    repeat (4) @(negedge CLK);
    build_model(addr, rw, size, wdata, port, berr);
    exp_rw = rw;
    exp_fc = fc;
    as_low_cnt = 0;
    txn_done = 0;
    txn_active = 1;
    REQ = 1'b1; REQ_ADDR = addr; REQ_RW = rw; REQ_SIZE = size; REQ_WDATA = wdata; REQ_FC = fc;
    @(posedge CLK);
    #1 acc_cyc = cyc;
    @(negedge CLK);
    check("busy_after_accept", 32'(BUSY), 32'd1);
    if (exp_lat >= 5) begin
      // A second request while busy must not disturb the captured operand.
      REQ_ADDR = $urandom;
      REQ_WDATA = $urandom;
      @(negedge CLK);
    end
    REQ = 1'b0;
    if (wait_done) begin
      for (int i = 0; i < 300 && !txn_done; i++) @(negedge CLK);
      if (!txn_done) begin
        check("ack_seen", 32'd0, 32'd1);
        txn_active = 0;
      end
    end
  endtask

  task automatic reset_mid_cycle();
    for (int i = 0; i < 20 && AS_n; i++) @(negedge CLK);
    check("as_low_before_reset", 32'(AS_n), 32'd0);
    @(posedge CLK);
    #3;
    txn_active = 0;
    exp_q.delete();
    RST_n = 1'b0;
    #1;
    check("rst_as_n", 32'(AS_n), 32'd1);
    check("rst_ds_n", 32'(DS_n), 32'd1);
    check("rst_d_oe", 32'(D_OE), 32'd0);
    repeat (2) @(negedge CLK);
    check("rst_ack", 32'(ACK), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    RST_n = 1'b1;
    repeat (2) @(negedge CLK);
    check("post_rst_ack", 32'(ACK), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] addr;
    logic [1:0]  size;
    int          port;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[3] = 8'hA5;
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
    mem[4] = 8'h78;

    repeat (3) @(negedge CLK);
    check("reset_as_n", 32'(AS_n), 32'd1);
    check("reset_ds_n", 32'(DS_n), 32'd1);
    check("reset_rw", 32'(RW), 32'd1);
    check("reset_d_oe", 32'(D_OE), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_ack", 32'(ACK), 32'd0);
    check("reset_rsp_err", 32'(RSP_ERR), 32'd0);
    check("reset_a", A, 32'd0);
    check("reset_siz_fc", {27'd0, SIZ, FC}, 32'd0);
    check("reset_d_out", D_OUT, 32'd0);
    check("reset_rdata", RSP_RDATA, 32'd0);
    RST_n = 1'b1;
    repeat (2) @(negedge CLK);

    // Byte read on an 8-bit port.
    run_txn(32'h8000_0003, 1'b1, 2'b01, 32'h0, 3'd5, 1, 1'b0, 1'b1);
    check("byte_rdata_lit", last_rdata, 32'h0000_00A5);
    check("byte_lat_lit", last_lat, 32'd5);

    // Long write on an 8-bit port.
    last_dbytes.delete();
    run_txn(32'h8000_0000, 1'b0, 2'b00, 32'h1122_3344, 3'd1, 1, 1'b0, 1'b1);
    check("lw_lat_lit", last_lat, 32'd17);
    check("lw_nbytes_lit", last_dbytes.size(), 32'd4);
    if (last_dbytes.size() == 4)
      check("lw_bytes_lit", {last_dbytes[0], last_dbytes[1], last_dbytes[2], last_dbytes[3]},
            32'h1122_3344);

    // Long read on a 16-bit port, bytes at 0x..00..03 = 12 34 56 ?? and 0x03 overwritten by A5.
    mem[3] = 8'h78;
    run_txn(32'hC000_0000, 1'b1, 2'b00, 32'h0, 3'd6, 2, 1'b0, 1'b1);
    check("lr16_rdata_lit", last_rdata, 32'h1234_5678);
    check("lr16_lat_lit", last_lat, 32'd9);

    // Bus error on the first sub-cycle, DSACK also asserted.
    run_txn(32'h8000_0010, 1'b1, 2'b00, 32'h0, 3'd2, 4, 1'b1, 1'b1);
    check("berr_err_lit", 32'(last_err), 32'd1);
    check("berr_lat_lit", last_lat, 32'd5);

    // Misaligned word.
    run_txn(32'h8000_0001, 1'b1, 2'b10, 32'h0, 3'd2, 4, 1'b0, 1'b1);
    check("mis_err_lit", 32'(last_err), 32'd1);
    check("mis_lat_lit", last_lat, 32'd1);

    // Unterminated read.
`ifdef BUS_TIMEOUT_EN
    run_txn(32'h8000_0020, 1'b1, 2'b00, 32'h0, 3'd3, 0, 1'b0, 1'b1);
    check("tmo_err_lit", 32'(last_err), 32'd1);
    check("tmo_lat_lit", last_lat, 32'd11);
`else
    run_txn(32'h8000_0020, 1'b1, 2'b00, 32'h0, 3'd3, 0, 1'b0, 1'b0);
    repeat (40) @(negedge CLK);
    check("hang_busy", 32'(BUSY), 32'd1);
    check("hang_no_ack", 32'(txn_done), 32'd0);
    check("hang_as_n", 32'(AS_n), 32'd0);
    reset_mid_cycle();
`endif

    // Reset during ASSERT of a write, then a normal request.
    run_txn(32'h8000_0040, 1'b0, 2'b00, 32'hDEAD_BEEF, 3'd1, 0, 1'b0, 1'b0);
    reset_mid_cycle();
    run_txn(32'h8000_0044, 1'b1, 2'b00, 32'h0, 3'd5, 4, 1'b0, 1'b1);

    for (int t = 0; t < 60; t++) begin
      size = 2'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        if (size == 2'b00) addr[1:0] = 2'b00;
        if (size == 2'b10) addr[0] = 1'b0;
      end
      case ($urandom_range(0, 2))
        0:       port = 1;
        1:       port = 2;
        default: port = 4;
      endcase
      run_txn(addr, 1'($urandom), size, $urandom, 3'($urandom), port,
              ($urandom_range(0, 7) == 0), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
